// File: rtl/sampq_arbiter_if.sv
// Sample-queue arbiter bus: per-channel sample heads, pull strobes and the
// merged output stream. The master modport is the arbiter side.
//
// Handshake: out_valid/out_ready is a strict valid/ready pair. A word moves
// only on a clock edge where out_valid && out_ready are both high. Once
// out_valid is raised, out_valid and out_data hold steady until that
// transfer. out_ready has no effect while out_valid is low. ch_pull is a
// one-cycle strobe with no acknowledge: the channel pops its head sample on
// that edge.
interface sampq_arbiter_if #(
    parameter int NUM_CH = 4
);
    logic [32*NUM_CH-1:0] ch_data;
    logic [8*NUM_CH-1:0]  ch_count;
    logic [NUM_CH-1:0]    ch_avail;
    logic [NUM_CH-1:0]    ch_pull;
    logic [31:0]          out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 busy;
    logic [2:0]           cur_ch;
    logic [1:0]           dbg_state;

    modport master (
        input  ch_data, ch_count, ch_avail, out_ready,
        output ch_pull, out_data, out_valid, busy, cur_ch, dbg_state
    );

    modport slave (
        output ch_data, ch_count, ch_avail, out_ready,
        input  ch_pull, out_data, out_valid, busy, cur_ch, dbg_state
    );
endinterface

// File: rtl/sampq_arbiter.sv
// Round-robin burst arbiter merging NUM_CH sample queues into one stream.
// Each burst is a header word (A5 | channel | count | seq) followed by
// count samples pulled one at a time from the granted channel.
// Optional macro SAMPQ_ARBITER_SEQ_EN: adds an 8-bit burst sequence counter
// reported in header bits [7:0]; without it those bits are zero.
// FSM state is exported on bus.dbg_state (0 IDLE, 1 HEADER, 2 PULL, 3 SEND).
module sampq_arbiter #(
    parameter int NUM_CH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    sampq_arbiter_if.master  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        PULL   = 2'd2,
        SEND   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        sel_q, sel_d;
    logic [2:0]        rr_ptr_q, rr_ptr_d;
    logic [2:0]        cur_ch_q, cur_ch_d;
    logic [7:0]        remaining_q, remaining_d;
    logic [NUM_CH-1:0] ch_pull_q, ch_pull_d;
    logic [31:0]       out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;
    logic              armed_q, armed_d;
    logic [7:0]        seq_val;

`ifdef SAMPQ_ARBITER_SEQ_EN
    logic [7:0]        seq_q, seq_d;
    assign seq_val = seq_q;
`else
    assign seq_val = 8'h00;
`endif

    logic              grant_found;
    logic [2:0]        grant_idx;
    logic [7:0]        grant_count;
    logic [NUM_CH-1:0] sel_onehot;
    logic [2:0]        sel_next;

    // Round-robin scan of ch_avail starting at rr_ptr; first hit wins
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = 3'd0;
        for (int k = 0; k < NUM_CH; k++) begin
            int idx;
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!grant_found && bus.ch_avail[idx]) begin
                grant_found = 1'b1;
                grant_idx   = 3'(idx);
            end
        end
        grant_count = bus.ch_count[8*grant_idx +: 8];
    end

    // Pull strobe pattern for the latched channel and the pointer after it
    always_comb begin
        sel_onehot = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sel_onehot[i] = (sel_q == 3'(i));
        end
        sel_next = (sel_q == 3'(NUM_CH - 1)) ? 3'd0 : sel_q + 3'd1;
    end

    // Next-state and registered-output logic for the burst FSM
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        rr_ptr_d    = rr_ptr_q;
        cur_ch_d    = cur_ch_q;
        remaining_d = remaining_q;
        ch_pull_d   = '0;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        armed_d     = 1'b1;
`ifdef SAMPQ_ARBITER_SEQ_EN
        seq_d       = seq_q;
`endif
        case (state_q)
            IDLE: begin
                out_valid_d = 1'b0;
                // armed_q keeps the first edge after reset release grant-free
                if (armed_q && grant_found) begin
                    sel_d       = grant_idx;
                    cur_ch_d    = grant_idx;
                    remaining_d = grant_count;
                    if (grant_count == 8'd0) begin
                        rr_ptr_d = (grant_idx == 3'(NUM_CH - 1)) ? 3'd0 : grant_idx + 3'd1;
                    end else begin
                        state_d     = HEADER;
                        out_valid_d = 1'b1;
                        out_data_d  = {8'hA5, 5'd0, grant_idx, grant_count, seq_val};
                    end
                end
            end
            HEADER: begin
                if (bus.out_ready) begin
                    state_d     = PULL;
                    out_valid_d = 1'b0;
                    ch_pull_d   = sel_onehot;
`ifdef SAMPQ_ARBITER_SEQ_EN
                    seq_d       = seq_q + 8'd1;
`endif
                end
            end
            PULL: begin
                out_data_d  = bus.ch_data[32*sel_q +: 32];
                remaining_d = remaining_q - 8'd1;
                out_valid_d = 1'b1;
                state_d     = SEND;
            end
            SEND: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    if (remaining_q != 8'd0) begin
                        state_d   = PULL;
                        ch_pull_d = sel_onehot;
                    end else begin
                        state_d  = IDLE;
                        rr_ptr_d = sel_next;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers, cleared asynchronously by rst_n
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= 3'd0;
            rr_ptr_q    <= 3'd0;
            cur_ch_q    <= 3'd0;
            remaining_q <= 8'd0;
            ch_pull_q   <= '0;
            out_data_q  <= 32'd0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            armed_q     <= 1'b0;
`ifdef SAMPQ_ARBITER_SEQ_EN
            seq_q       <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            rr_ptr_q    <= rr_ptr_d;
            cur_ch_q    <= cur_ch_d;
            remaining_q <= remaining_d;
            ch_pull_q   <= ch_pull_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            armed_q     <= armed_d;
`ifdef SAMPQ_ARBITER_SEQ_EN
            seq_q       <= seq_d;
`endif
        end
    end

    assign bus.ch_pull   = ch_pull_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.cur_ch    = cur_ch_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_sampq_arbiter.sv
// Directed bench for sampq_arbiter: channel models whose head sample encodes
// channel and pop index, an expected-word queue, and per-cycle protocol checks.
module tb_sampq_arbiter;
    localparam int NUM_CH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sampq_arbiter_if #(.NUM_CH(NUM_CH)) bus ();

    sampq_arbiter #(.NUM_CH(NUM_CH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0]       exp_q[$];
    int                checks = 0;
    int                errors = 0;
    int                hdr_cnt = 0;
    int                exp_idx[NUM_CH];
    logic [7:0]        tb_seq = 8'd0;
    logic [15:0]       pull_cnt[NUM_CH];
    logic [NUM_CH-1:0] avail = '0;
    logic [7:0]        cnt[NUM_CH];
    logic              ready = 1'b1;
    logic [NUM_CH-1:0] prev_pull;
    logic              prev_valid;
    logic              prev_ready;
    logic [31:0]       prev_data;
    logic [32*NUM_CH-1:0] data_vec;
    logic [8*NUM_CH-1:0]  count_vec;

    // Channel head sample = D | channel | 00 | number of pops so far
    always_comb begin
        data_vec  = '0;
        count_vec = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            data_vec[32*i +: 32] = {4'hD, 4'(i), 8'h00, pull_cnt[i]};
            count_vec[8*i +: 8]  = cnt[i];
        end
    end

    assign bus.ch_data   = data_vec;
    assign bus.ch_count  = count_vec;
    assign bus.ch_avail  = avail;
    assign bus.out_ready = ready;

    // Each pull strobe pops one sample from that channel
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) pull_cnt[i] <= 16'd0;
        end else begin
            for (int i = 0; i < NUM_CH; i++)
                if (bus.ch_pull[i]) pull_cnt[i] <= pull_cnt[i] + 16'd1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Scoreboard and protocol monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_pull  = '0;
            prev_valid = 1'b0;
            prev_ready = 1'b0;
            prev_data  = 32'd0;
        end else begin
            if (prev_valid && !prev_ready) begin
                check("hold_valid", {31'b0, bus.out_valid}, 32'd1);
                check("hold_data", bus.out_data, prev_data);
            end
            if (bus.ch_pull != '0) begin
                check("pull_onehot", {31'b0, $onehot(bus.ch_pull)}, 32'd1);
                check("pull_gap", 32'(bus.ch_pull & prev_pull), 32'd0);
                check("pull_no_valid", {31'b0, bus.out_valid}, 32'd0);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("word_expected", 32'(exp_q.size()), 32'd1);
                end else begin
                    logic [31:0] w;
                    w = exp_q.pop_front();
                    check("out_word", bus.out_data, w);
                    if (w[31:24] == 8'hA5) hdr_cnt++;
                end
            end
            prev_pull  = bus.ch_pull;
            prev_valid = bus.out_valid;
            prev_ready = bus.out_ready;
            prev_data  = bus.out_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        exp_q.delete();
        for (int i = 0; i < NUM_CH; i++) begin
            exp_idx[i] = 0;
            cnt[i]     = 8'd0;
        end
        tb_seq = 8'd0;
        avail  = '0;
        ready  = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic expect_burst(input int ch, input int n);
        logic [7:0] s;
`ifdef SAMPQ_ARBITER_SEQ_EN
        s = tb_seq;
`else
        s = 8'h00;
`endif
        exp_q.push_back({8'hA5, 5'd0, 3'(ch), 8'(n), s});
        tb_seq = tb_seq + 8'd1;
        for (int k = 0; k < n; k++) begin
            exp_q.push_back({4'hD, 4'(ch), 8'h00, 16'(exp_idx[ch])});
            exp_idx[ch]++;
        end
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int   n;
        logic done;
        n    = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            step();
            n++;
            done = (exp_q.size() == 0) && !bus.busy && !bus.out_valid;
        end
        check(tag, {31'b0, done}, 32'd1);
    endtask

    task automatic wait_busy(input int budget, input string tag);
        int n;
        n = 0;
        while (!bus.busy && n < budget) begin
            step();
            n++;
        end
        check(tag, {31'b0, bus.busy}, 32'd1);
    endtask

    task automatic wait_hdr(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (hdr_cnt < target && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(hdr_cnt >= target), 32'd1);
    endtask

    initial begin
        int       base;
        int       n;
        logic     found;
        logic [15:0] pc;

        // Reset values, with a burst request already pending
        clear_model();
        avail  = 4'b0010;
        cnt[1] = 8'd3;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_ch_pull", 32'(bus.ch_pull), 32'd0);
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_cur_ch", {29'b0, bus.cur_ch}, 32'd0);
        check("rst_out_data", bus.out_data, 32'd0);
        check("rst_state", {30'b0, bus.dbg_state}, 32'd0);

        // Single burst of 3 from channel 1; no grant on first edge after release
        expect_burst(1, 3);
        rst_n = 1'b1;
        step();
        check("first_edge_idle", {31'b0, bus.busy}, 32'd0);
        step();
        check("second_edge_grant", {31'b0, bus.busy}, 32'd1);
        check("grant_cur_ch", {29'b0, bus.cur_ch}, 32'd1);
        avail = '0;
        wait_idle(40, "burst1_done");
        check("burst1_pulls", 32'(pull_cnt[1]), 32'd3);

        // All channels ready, one sample each: order 0,1,2,3,0
        do_reset();
        avail = 4'b1111;
        for (int i = 0; i < NUM_CH; i++) cnt[i] = 8'd1;
        expect_burst(0, 1);
        expect_burst(1, 1);
        expect_burst(2, 1);
        expect_burst(3, 1);
        expect_burst(0, 1);
        base = hdr_cnt;
        wait_hdr(base + 5, 100, "rr_headers");
        avail = '0;
        wait_idle(40, "rr_done");

        // Zero-count channel 2 is skipped, pointer moves on to channel 3
        avail  = 4'b1100;
        cnt[2] = 8'd0;
        cnt[3] = 8'd2;
        expect_burst(3, 2);
        step();
        check("zero_cnt_busy", {31'b0, bus.busy}, 32'd0);
        check("zero_cnt_cur_ch", {29'b0, bus.cur_ch}, 32'd2);
        step();
        check("next_grant_busy", {31'b0, bus.busy}, 32'd1);
        check("next_grant_cur_ch", {29'b0, bus.cur_ch}, 32'd3);
        avail = '0;
        wait_idle(40, "zero_cnt_done");

        // Consumer stalls for 5 cycles on the first sample word
        do_reset();
        avail  = 4'b0001;
        cnt[0] = 8'd2;
        expect_burst(0, 2);
        n     = 0;
        found = 1'b0;
        while (!found && n < 20) begin
            step();
            n++;
            found = bus.out_valid && (bus.out_data[31:28] == 4'hD);
        end
        check("stall_reach_send", {31'b0, found}, 32'd1);
        ready = 1'b0;
        avail = '0;
        pc    = pull_cnt[0];
        repeat (5) step();
        check("stall_valid", {31'b0, bus.out_valid}, 32'd1);
        check("stall_no_pull", 32'(pull_cnt[0]), 32'(pc));
        ready = 1'b1;
        wait_idle(40, "stall_done");

        // Reset during a burst with 5 samples still to go
        do_reset();
        avail  = 4'b0001;
        cnt[0] = 8'd8;
        expect_burst(0, 8);
        n     = 0;
        found = 1'b0;
        while (!found && n < 40) begin
            step();
            n++;
            found = (pull_cnt[0] == 16'd3) && bus.ch_pull[0];
        end
        check("midburst_reach", {31'b0, found}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async_ch_pull", 32'(bus.ch_pull), 32'd0);
        check("async_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("async_busy", {31'b0, bus.busy}, 32'd0);
        check("async_out_data", bus.out_data, 32'd0);
        clear_model();
        avail  = 4'b0001;
        cnt[0] = 8'd1;
        expect_burst(0, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_busy(10, "fresh_grant");
        check("fresh_cur_ch", {29'b0, bus.cur_ch}, 32'd0);
        avail = '0;
        wait_idle(40, "fresh_done");

        // Random-length burst on channel 1 under random backpressure
        n      = $urandom_range(2, 6);
        avail  = 4'b0010;
        cnt[1] = 8'(n);
        expect_burst(1, n);
        wait_busy(10, "rand_grant");
        avail = '0;
        n     = 0;
        found = 1'b0;
        while (!found && n < 200) begin
            ready = 1'($urandom_range(0, 1));
            step();
            n++;
            found = (exp_q.size() == 0) && !bus.busy && !bus.out_valid;
        end
        ready = 1'b1;
        check("rand_done", {31'b0, found}, 32'd1);

        // 257 one-sample bursts: header sequence field wraps 255 -> 0
        do_reset();
        avail  = 4'b0001;
        cnt[0] = 8'd1;
        for (int b = 0; b < 257; b++) expect_burst(0, 1);
        base = hdr_cnt;
        wait_hdr(base + 257, 3000, "seq_headers");
        avail = '0;
        wait_idle(50, "seq_done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
